// File: rtl/spi_slave_resp_if.sv
// spi_slave_resp_if
//   Bundle of the SPI pins and the local word-side handshake of spi_slave_resp.
//   slave modport  : view of the responder (spi_slave_resp).
//   master modport : view of whatever drives the pins and consumes words
//                    (SPI controller model plus local logic).
// Signals
//   sclk_i, cs_i, mosi_i      SPI pins from the controller (asynchronous)
//   miso_o, miso_oe_o         SPI data out and its drive enable
//   tx_data_i/valid_i/ready_o transmit holding-buffer write handshake
//   rx_data_o, rx_valid_o     received word and its one-cycle strobe
//   underrun_o, abort_o       one-cycle event strobes
//   busy_o                    frame in progress
interface spi_slave_resp_if #(
    parameter int DATA_W = 8
);
    logic              sclk_i;
    logic              cs_i;
    logic              mosi_i;
    logic              miso_o;
    logic              miso_oe_o;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              underrun_o;
    logic              abort_o;
    logic              busy_o;

    modport slave (
        input  sclk_i, cs_i, mosi_i, tx_data_i, tx_valid_i,
        output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
               underrun_o, abort_o, busy_o
    );

    modport master (
        output sclk_i, cs_i, mosi_i, tx_data_i, tx_valid_i,
        input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
               underrun_o, abort_o, busy_o
    );
endinterface

// File: rtl/spi_slave_resp.sv
// spi_slave_resp
//   SPI responder for a mode-3 link (SCLK idles high, CS active-high).
//   SCLK, CS and MOSI are oversampled in the clk_i domain. MOSI is captured on
//   SCLK rising edges into words delivered on rx_data_o/rx_valid_o. A one-entry
//   transmit holding buffer is shifted out on MISO from SCLK falling edges;
//   when the buffer is empty at a word load, TX_FILL is sent and underrun_o
//   pulses.
// Ports
//   clk_i   system clock, must run at least 8x the SCLK frequency
//   rst_i   synchronous active-high reset
//   bus     spi_slave_resp_if.slave (SPI pins + word handshake)
// Parameters
//   DATA_W  word length in bits (>= 2)
//   TX_FILL word sent when the transmit buffer is empty at a word load
// Build option
//   SPI_RESP_LSB_FIRST_EN : when defined, TX and RX are LSB first; otherwise
//                           MSB first in both directions.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_REL  | after reset; waits for CS low so a frame already running is
//           | ignored
// IDLE      | CS low, waiting for CS rise
// ACTIVE    | frame in progress, shifting on SCLK edges
module spi_slave_resp #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] TX_FILL = 8'hFF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    spi_slave_resp_if.slave       bus
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_WAIT_REL = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    state_t            state_q,      state_d;
    logic [2:0]        sclk_sync_q,  sclk_sync_d;
    logic [2:0]        cs_sync_q,    cs_sync_d;
    logic [1:0]        mosi_sync_q,  mosi_sync_d;
    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0] tx_shift_q,   tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q,   rx_shift_d;
    logic [DATA_W-1:0] buf_data_q,   buf_data_d;
    logic              buf_full_q,   buf_full_d;
    logic              miso_q,       miso_d;
    logic [DATA_W-1:0] rx_data_q,    rx_data_d;
    logic              rx_valid_q,   rx_valid_d;
    logic              underrun_q,   underrun_d;
    logic              abort_q,      abort_d;

    logic              sclk_rise, sclk_fall;
    logic              cs_rise, cs_fall;
    logic              cs_s, mosi_s;
    logic              last_bit;
    logic              load;
    logic              wr;
    logic [DATA_W-1:0] rx_word;

    // Index 1 is the synchronised level, index 2 the previous level.
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign cs_rise   =  cs_sync_q[1]   & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1]   &  cs_sync_q[2];

    assign last_bit  = (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign wr        = bus.tx_valid_i & ~buf_full_q;

`ifdef SPI_RESP_LSB_FIRST_EN
    assign rx_word   = {mosi_s, rx_shift_q[DATA_W-1:1]};
`else
    assign rx_word   = {rx_shift_q[DATA_W-2:0], mosi_s};
`endif

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], bus.sclk_i};
        cs_sync_d   = {cs_sync_q[1:0],   bus.cs_i};
        mosi_sync_d = {mosi_sync_q[0],   bus.mosi_i};

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        buf_data_d  = buf_data_q;
        buf_full_d  = buf_full_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        load        = 1'b0;

        case (state_q)
            ST_WAIT_REL: begin
                if (!cs_s) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (cs_rise) begin
                    state_d = ST_ACTIVE;
                    load    = 1'b1;
                end
            end

            ST_ACTIVE: begin
                if (sclk_fall) begin
`ifdef SPI_RESP_LSB_FIRST_EN
                    miso_d     = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
`else
                    miso_d     = tx_shift_q[DATA_W-1];
                    tx_shift_d = tx_shift_q << 1;
`endif
                end

                if (sclk_rise) begin
                    if (last_bit) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        // A word completing as CS drops ends the frame; no
                        // reload, so the buffer keeps its word for next frame.
                        load       = ~cs_fall;
                    end else begin
                        rx_shift_d = rx_word;
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end
                end

                if (cs_fall) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    if ((bit_cnt_q != '0) && !(sclk_rise && last_bit)) begin
                        abort_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_WAIT_REL;
            end
        endcase

        // Load sees the buffer as it was before this cycle's write, so a write
        // landing together with a load on an empty buffer is kept for the next
        // load while this one sends TX_FILL.
        if (load) begin
            bit_cnt_d = '0;
            if (buf_full_q) begin
                tx_shift_d = buf_data_q;
                buf_full_d = 1'b0;
            end else begin
                tx_shift_d = TX_FILL;
                underrun_d = 1'b1;
            end
        end

        if (wr) begin
            buf_data_d = bus.tx_data_i;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_WAIT_REL;
            // Sync flops start at the idle/busy levels: SCLK high and CS
            // assumed asserted, so no strobe fires and WAIT_REL only leaves
            // once CS is genuinely seen low.
            sclk_sync_q <= 3'b111;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            buf_data_q  <= '0;
            buf_full_q  <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            buf_data_q  <= buf_data_d;
            buf_full_q  <= buf_full_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.miso_o     = (state_q == ST_ACTIVE) ? miso_q : 1'b0;
    assign bus.miso_oe_o  = (state_q == ST_ACTIVE);
    assign bus.busy_o     = (state_q == ST_ACTIVE);
    assign bus.tx_ready_o = ~buf_full_q;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.underrun_o = underrun_q;
    assign bus.abort_o    = abort_q;

endmodule

// File: tb/tb_spi_slave_resp.sv
// Testbench for spi_slave_resp: drives a mode-3 SPI controller model and the
// transmit handshake; expected RX words and MISO words are queued as frames
// are driven and popped as the DUT produces them.
module tb_spi_slave_resp;

    localparam int DATA_W = 8;
    localparam int HALF   = 8;
    localparam int SETUP  = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    spi_slave_resp_if #(.DATA_W(DATA_W)) bus ();

    spi_slave_resp #(
        .DATA_W  (DATA_W),
        .TX_FILL (8'hFF)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int underrun_cnt = 0;
    int abort_cnt    = 0;
    int exp_underrun = 0;
    int exp_abort    = 0;

    logic [7:0] rxq[$];
    logic [7:0] misoq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor, sampled on the falling clk edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (bus.underrun_o) underrun_cnt++;
            if (bus.abort_o)    abort_cnt++;
            if (bus.rx_valid_o) begin
                if (rxq.size() == 0) check("rx_unexpected", {31'd0, bus.rx_valid_o}, 32'd0);
                else                 check("rx_data", {24'd0, bus.rx_data_o}, {24'd0, rxq.pop_front()});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // One SPI bit per iteration: fall, set MOSI, half period, sample MISO, rise.
    task automatic spi_xfer(input logic [7:0] mosi_w, input int nbits, output logic [7:0] miso_w);
        int idx;
        miso_w = '0;
        for (int i = 0; i < nbits; i++) begin
`ifdef SPI_RESP_LSB_FIRST_EN
            idx = i;
`else
            idx = 7 - i;
`endif
            @(negedge clk_i);
            bus.sclk_i = 1'b0;
            bus.mosi_i = mosi_w[idx];
            repeat (HALF) @(negedge clk_i);
            miso_w[idx] = bus.miso_o;
            bus.sclk_i = 1'b1;
            repeat (HALF) @(negedge clk_i);
        end
    endtask

    task automatic spi_word(input logic [7:0] mosi_w, input logic [7:0] exp_miso);
        logic [7:0] got;
        rxq.push_back(mosi_w);
        misoq.push_back(exp_miso);
        spi_xfer(mosi_w, 8, got);
        check("miso_word", {24'd0, got}, {24'd0, misoq.pop_front()});
    endtask

    task automatic cs_up();
        @(negedge clk_i);
        bus.cs_i = 1'b1;
        repeat (SETUP) @(negedge clk_i);
    endtask

    task automatic cs_down();
        @(negedge clk_i);
        bus.cs_i = 1'b0;
        repeat (12) @(negedge clk_i);
        check("rx_pending", rxq.size(), 32'd0);
        check("busy_after_cs", {31'd0, bus.busy_o}, 32'd0);
    endtask

    task automatic tx_write(input logic [7:0] d);
        int n = 0;
        @(negedge clk_i);
        while (!bus.tx_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) check("tx_ready_wait", {31'd0, bus.tx_ready_o}, 32'd1);
        bus.tx_data_i  = d;
        bus.tx_valid_i = 1'b1;
        @(negedge clk_i);
        bus.tx_valid_i = 1'b0;
    endtask

    logic [7:0] dummy;

    initial begin
        bus.sclk_i     = 1'b1;
        bus.cs_i       = 1'b1;
        bus.mosi_i     = 1'b0;
        bus.tx_data_i  = '0;
        bus.tx_valid_i = 1'b0;

        // Reset with CS high mid-frame.
        repeat (4) @(negedge clk_i);
        check("rst_miso",     {31'd0, bus.miso_o},     32'd0);
        check("rst_miso_oe",  {31'd0, bus.miso_oe_o},  32'd0);
        check("rst_tx_ready", {31'd0, bus.tx_ready_o}, 32'd1);
        check("rst_rx_data",  {24'd0, bus.rx_data_o},  32'd0);
        check("rst_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        check("rst_underrun", {31'd0, bus.underrun_o}, 32'd0);
        check("rst_abort",    {31'd0, bus.abort_o},    32'd0);
        check("rst_busy",     {31'd0, bus.busy_o},     32'd0);
        rst_i = 1'b0;

        // Frame in progress at reset release must be ignored.
        spi_xfer(8'h5A, 8, dummy);
        check("wait_rel_busy", {31'd0, bus.busy_o}, 32'd0);
        cs_down();
        check("wait_rel_underrun", underrun_cnt, exp_underrun);

        // Empty buffer: fill word, then A5 received.
        cs_up();
        exp_underrun++;
        check("active_busy",    {31'd0, bus.busy_o},    32'd1);
        check("active_miso_oe", {31'd0, bus.miso_oe_o}, 32'd1);
        spi_word(8'hA5, 8'hFF);
        exp_underrun++;
        cs_down();
        check("rx_hold_a5", {24'd0, bus.rx_data_o}, 32'h0A5);
        check("underrun_a", underrun_cnt, exp_underrun);

        // Preloaded 3C.
        tx_write(8'h3C);
        check("tx_ready_full", {31'd0, bus.tx_ready_o}, 32'd0);
        cs_up();
        check("tx_ready_after_load", {31'd0, bus.tx_ready_o}, 32'd1);
        spi_word(8'h5A, 8'h3C);
        exp_underrun++;
        cs_down();
        check("rx_hold_5a", {24'd0, bus.rx_data_o}, 32'h05A);
        check("underrun_b", underrun_cnt, exp_underrun);

        // Underrun then a mid-frame write on the second word.
        cs_up();
        exp_underrun++;
        check("underrun_c", underrun_cnt, exp_underrun);
        tx_write(8'h81);
        spi_word(8'h11, 8'hFF);
        spi_word(8'h22, 8'h81);
        exp_underrun++;
        cs_down();
        check("underrun_d", underrun_cnt, exp_underrun);

        // Back-to-back with both words buffered in time.
        tx_write(8'hC3);
        cs_up();
        tx_write(8'h0F);
        spi_word(8'h12, 8'hC3);
        spi_word(8'h34, 8'h0F);
        exp_underrun++;
        cs_down();
        check("underrun_e", underrun_cnt, exp_underrun);

        // Abort after 5 bits.
        cs_up();
        exp_underrun++;
        spi_xfer(8'hFF, 5, dummy);
        cs_down();
        exp_abort++;
        check("abort_cnt", abort_cnt, exp_abort);
        check("rx_hold_abort", {24'd0, bus.rx_data_o}, 32'h034);

        cs_up();
        exp_underrun++;
        spi_word(8'h00, 8'hFF);
        exp_underrun++;
        cs_down();
        check("rx_hold_00", {24'd0, bus.rx_data_o}, 32'h000);

        // Single set bit: order-sensitive in both directions.
        tx_write(8'h01);
        cs_up();
        spi_word(8'h01, 8'h01);
        exp_underrun++;
        cs_down();
        check("rx_hold_01", {24'd0, bus.rx_data_o}, 32'h001);

        check("underrun_total", underrun_cnt, exp_underrun);
        check("abort_total",    abort_cnt,    exp_abort);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
